// File: rtl/shifter_arbiter.sv
// Purpose: round-robin share of one 8-bit combinational shifter between requesters A and B.
// Latency: ack in cycle N, registered result valid from cycle N+2; at least 3 cycles per operation, no overlap.
// Backpressure: result, id and valid hold in DONE until res_ready; requests are not acked until then.

module shifter (
    input  logic [7:0] data,
    input  logic [2:0] amt,
    input  logic [1:0] op,
    output logic [7:0] result
);

    logic [15:0] rot;

    // 00 lsl, 01 lsr, 10 asr, 11 rotate left; amt 0 passes data through for every op
    always_comb begin
        rot    = {data, data} << amt;
        result = data;
        case (op)
            2'b00:   result = data << amt;
            2'b01:   result = data >> amt;
            2'b10:   result = $signed(data) >>> amt;
            default: result = rot[15:8];
        endcase
    end

endmodule

module shifter_arbiter #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic [AMT_W-1:0] amt_a,
    input  logic [1:0]       op_a,
    output logic             ack_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    input  logic [AMT_W-1:0] amt_b,
    input  logic [1:0]       op_b,
    output logic             ack_b,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] opnd;
    logic [AMT_W-1:0] amt_r;
    logic [1:0]       op_r;
    logic             grant_id;
    logic             ptr;        // 0 favours A, 1 favours B
    logic             win_b;
    logic             any_req;
    logic [WIDTH-1:0] shift_out;

    // B wins if it is the only requester, or both request and the pointer favours B
    always_comb begin
        any_req = req_a || req_b;
        win_b   = req_b && (!req_a || ptr);
    end

    // Ack marks the IDLE cycle whose closing edge captures the operands; masked while in reset
    assign ack_a = (state == IDLE) && !reset && req_a && !win_b;
    assign ack_b = (state == IDLE) && !reset && win_b;
    assign busy  = (state != IDLE);

    shifter u_shifter (
        .data   (opnd),
        .amt    (amt_r),
        .op     (op_r),
        .result (shift_out)
    );

    // Sequencer: capture winner in IDLE, latch shifter output in EXEC, hold result in DONE until accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            opnd      <= '0;
            amt_r     <= '0;
            op_r      <= '0;
            grant_id  <= 1'b0;
            ptr       <= 1'b0;
            res_data  <= '0;
            res_id    <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        opnd     <= win_b ? data_b : data_a;
                        amt_r    <= win_b ? amt_b  : amt_a;
                        op_r     <= win_b ? op_b   : op_a;
                        grant_id <= win_b;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    res_data  <= shift_out;
                    res_id    <= grant_id;
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        // favour the requester that was not just served
                        ptr       <= ~grant_id;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shifter_arbiter.sv
// Purpose: randomized and directed bench for shifter_arbiter against an arithmetic reference model.
// Latency: inputs driven away from posedge, outputs sampled 1 ns after the negedge.
// Backpressure: exercises res_ready held low in DONE and continuous ready.

module tb_shifter_arbiter;

    logic       clk;
    logic       reset;
    logic       req_a, req_b;
    logic [7:0] data_a, data_b;
    logic [2:0] amt_a, amt_b;
    logic [1:0] op_a, op_b;
    logic       ack_a, ack_b;
    logic [7:0] res_data;
    logic       res_id, res_valid, res_ready, busy;

    int vectors = 0;
    int errors  = 0;
    bit tb_ptr  = 1'b0;   // model of the priority pointer: 0 = A favoured

    shifter_arbiter #(.WIDTH(8), .AMT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_a     (req_a),
        .data_a    (data_a),
        .amt_a     (amt_a),
        .op_a      (op_a),
        .ack_a     (ack_a),
        .req_b     (req_b),
        .data_b    (data_b),
        .amt_b     (amt_b),
        .op_b      (op_b),
        .ack_b     (ack_b),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // Reference: shift semantics from plain integer arithmetic
    function automatic logic [7:0] shift_ref(input logic [7:0] d, input logic [2:0] a, input logic [1:0] op);
        int v, r, n;
        v = int'(d);
        n = int'(a);
        case (op)
            2'b00:   r = (v * (1 << n)) % 256;
            2'b01:   r = v / (1 << n);
            2'b10:   begin
                         if (v >= 128) v = v - 256;
                         r = (v >>> n) & 255;
                     end
            default: r = ((v << n) | (v >> (8 - n))) % 256;
        endcase
        return r[7:0];
    endfunction

    // Waits (bounded) until either ack is observed; ok=0 on timeout
    task automatic wait_ack(output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 20) begin
            #1;
            if (ack_a || ack_b) ok = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    // One full request/result/handshake transaction checked against the model
    task automatic run_txn(input bit ra, input bit rb,
                           input logic [7:0] da, input logic [2:0] aa, input logic [1:0] oa,
                           input logic [7:0] db, input logic [2:0] ab, input logic [1:0] ob,
                           input int hold, input bit scramble, output bit win);
        bit         ok;
        bit         eb;
        logic [7:0] er;
        int         r;
        eb = rb && (!ra || tb_ptr);
        er = eb ? shift_ref(db, ab, ob) : shift_ref(da, aa, oa);
        req_a = ra; data_a = da; amt_a = aa; op_a = oa;
        req_b = rb; data_b = db; amt_b = ab; op_b = ob;
        wait_ack(ok);
        vectors++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL ack_timeout: got no ack required ack within 20 cycles");
        end
        vectors++;
        if ({ack_a, ack_b, busy} !== {!eb, eb, 1'b0}) begin
            errors++;
            $display("FAIL grant: got ack_a/ack_b/busy=%b%b%b required %b%b0", ack_a, ack_b, busy, !eb, eb);
        end
        @(posedge clk); #1;
        req_a = 1'b0; req_b = 1'b0;
        if (scramble) begin
            r = $urandom;
            data_a = 8'hFF; data_b = 8'hFF;
            amt_a = r[2:0]; amt_b = r[5:3]; op_a = r[7:6]; op_b = r[9:8];
        end
        @(negedge clk); #1;
        vectors++;
        if ({busy, res_valid, ack_a, ack_b} !== 4'b1000) begin
            errors++;
            $display("FAIL exec_cycle: got busy/valid/ack_a/ack_b=%b%b%b%b required 1000", busy, res_valid, ack_a, ack_b);
        end
        @(negedge clk); #1;
        vectors++;
        if ({res_valid, res_id, res_data} !== {1'b1, eb, er}) begin
            errors++;
            $display("FAIL result: got valid=%b id=%b data=%h required valid=1 id=%b data=%h", res_valid, res_id, res_data, eb, er);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); #1;
            vectors++;
            if ({res_valid, res_id, res_data, busy, ack_a, ack_b} !== {1'b1, eb, er, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL hold: got valid=%b id=%b data=%h busy=%b acks=%b%b required 1 %b %h 1 00",
                         res_valid, res_id, res_data, busy, ack_a, ack_b, eb, er);
            end
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        tb_ptr = !eb;
        @(negedge clk); #1;
        vectors++;
        if ({res_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL release: got valid/busy=%b%b required 00", res_valid, busy);
        end
        win = eb;
    endtask

    task automatic test_reset();
        reset = 1'b1; res_ready = 1'b0;
        req_a = 1'b0; data_a = '0; amt_a = '0; op_a = '0;
        req_b = 1'b0; data_b = '0; amt_b = '0; op_b = '0;
        #1;
        vectors++;
        if ({res_valid, res_id, res_data, ack_a, ack_b, busy} !== 13'd0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b id=%b data=%h acks=%b%b busy=%b required all zero",
                     res_valid, res_id, res_data, ack_a, ack_b, busy);
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        tb_ptr = 1'b0;
    endtask

    task automatic test_a_only();
        bit w;
        run_txn(1'b1, 1'b0, 8'h01, 3'd1, 2'b00, 8'h00, 3'd0, 2'b00, 3, 1'b0, w);
    endtask

    task automatic test_b_only();
        bit w;
        run_txn(1'b0, 1'b1, 8'h00, 3'd0, 2'b00, 8'h8E, 3'd1, 2'b01, 0, 1'b0, w);
        run_txn(1'b0, 1'b1, 8'h00, 3'd0, 2'b00, 8'h8E, 3'd1, 2'b10, 0, 1'b0, w);
        run_txn(1'b0, 1'b1, 8'h00, 3'd0, 2'b00, 8'h8E, 3'd1, 2'b11, 1, 1'b0, w);
        run_txn(1'b0, 1'b1, 8'h00, 3'd0, 2'b00, 8'hA5, 3'd0, 2'b10, 0, 1'b0, w);
    endtask

    task automatic test_both_alternate();
        bit         ok;
        bit         side;
        int         c;
        logic [7:0] er;
        reset = 1'b1;
        req_a = 1'b1; data_a = 8'h8E; amt_a = 3'd0; op_a = 2'b11;
        req_b = 1'b1; data_b = 8'h01; amt_b = 3'd7; op_b = 2'b00;
        #1;
        vectors++;
        if ({ack_a, ack_b, res_valid} !== 3'b000) begin
            errors++;
            $display("FAIL ack_in_reset: got acks/valid=%b%b%b required 000", ack_a, ack_b, res_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        tb_ptr = 1'b0;
        res_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            side = tb_ptr;
            er = side ? shift_ref(8'h01, 3'd7, 2'b00) : shift_ref(8'h8E, 3'd0, 2'b11);
            wait_ack(ok);
            vectors++;
            if ({ok, ack_a, ack_b} !== {1'b1, !side, side}) begin
                errors++;
                $display("FAIL alternate_grant: got ok/ack_a/ack_b=%b%b%b required 1%b%b", ok, ack_a, ack_b, !side, side);
            end
            c = 0;
            do begin
                @(negedge clk); #1;
                c++;
            end while (!res_valid && c < 10);
            vectors++;
            if ({c[3:0], res_id, res_data} !== {4'd2, side, er}) begin
                errors++;
                $display("FAIL alternate_result: got cycles=%0d id=%b data=%h required cycles=2 id=%b data=%h",
                         c, res_id, res_data, side, er);
            end
            tb_ptr = !side;
            if (k == 5) begin
                req_a = 1'b0;
                req_b = 1'b0;
            end
        end
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk); #1;
        vectors++;
        if ({res_valid, busy, ack_a, ack_b} !== 4'b0000) begin
            errors++;
            $display("FAIL alternate_end: got valid/busy/acks=%b%b%b%b required 0000", res_valid, busy, ack_a, ack_b);
        end
    endtask

    task automatic test_backpressure();
        bit w1, w2;
        run_txn(1'b1, 1'b1, 8'h5A, 3'd3, 2'b01, 8'hC3, 3'd2, 2'b10, 10, 1'b0, w1);
        run_txn(1'b1, 1'b1, 8'h81, 3'd1, 2'b11, 8'h7E, 3'd4, 2'b00, 0, 1'b0, w2);
        vectors++;
        if (w2 !== !w1) begin
            errors++;
            $display("FAIL backpressure_turn: got second winner %b required %b", w2, !w1);
        end
    endtask

    task automatic test_operand_change();
        bit w;
        run_txn(1'b1, 1'b0, 8'h01, 3'd1, 2'b00, 8'h00, 3'd0, 2'b00, 0, 1'b1, w);
    endtask

    task automatic test_reset_mid_done();
        bit ok;
        req_b = 1'b1; data_b = 8'hFF; amt_b = 3'd0; op_b = 2'b01;
        wait_ack(ok);
        @(posedge clk); #1;
        @(negedge clk); @(negedge clk); #1;
        vectors++;
        if ({ok, res_valid, res_id, res_data} !== {1'b1, 1'b1, 1'b1, 8'hFF}) begin
            errors++;
            $display("FAIL pre_reset_done: got ok=%b valid=%b id=%b data=%h required 1 1 1 ff", ok, res_valid, res_id, res_data);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({res_valid, res_id, res_data, ack_a, ack_b, busy} !== 13'd0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b id=%b data=%h acks=%b%b busy=%b required all zero",
                     res_valid, res_id, res_data, ack_a, ack_b, busy);
        end
        @(negedge clk); @(negedge clk);
        req_b = 1'b0;
        reset = 1'b0;
        tb_ptr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            vectors++;
            if ({res_valid, busy, ack_a, ack_b} !== 4'b0000) begin
                errors++;
                $display("FAIL post_reset_idle: got valid/busy/acks=%b%b%b%b required 0000", res_valid, busy, ack_a, ack_b);
            end
        end
    endtask

    task automatic test_random();
        bit ra, rb, w;
        int r1, r2;
        for (int k = 0; k < 30; k++) begin
            r1 = $urandom;
            r2 = $urandom;
            ra = r1[0];
            rb = r1[1] | !r1[0];
            run_txn(ra, rb, r1[15:8], r1[18:16], r1[20:19], r2[7:0], r2[10:8], r2[12:11],
                    int'(r2[14:13]), r2[15], w);
        end
    endtask

    initial begin
        test_reset();
        test_a_only();
        test_b_only();
        test_both_alternate();
        test_backpressure();
        test_operand_change();
        test_reset_mid_done();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
